// File: rtl/montgomery_mult.sv
// Radix-2 bit-serial Montgomery multiplier: out = A*B*2^(-WIDTH) mod N.
// One multiplicand bit is consumed per clock; fixed latency of WIDTH+2 cycles
// from the accepting edge to the out_ready pulse.
module montgomery_mult #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             beg,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] out,
  output logic             out_ready,
  output logic             busy
);

  // Accumulator carries two extra bits: P < 2N, and P + B + N < 4N.
  localparam int unsigned PW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOOP  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    p_q;
  logic [PW-1:0]    p_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] out_q;
  logic             out_ready_q;
  logic             busy_q;

  logic [PW-1:0]    t_add_c;
  logic [PW-1:0]    t_odd_c;
  logic [WIDTH-1:0] res_c;

  // One Montgomery iteration on the current LSB of the shifted multiplicand.
  always_comb begin
    t_add_c = '0;
    t_odd_c = '0;
    p_d     = '0;
    t_add_c = p_q + (a_q[0] ? PW'(b_q) : PW'(0));
    t_odd_c = t_add_c[0] ? (t_add_c + PW'(n_q)) : t_add_c;
    p_d     = t_odd_c >> 1;
  end

  // Final conditional subtraction brings P from [0, 2N) into [0, N).
  always_comb begin
    res_c = '0;
    res_c = WIDTH'((p_q >= PW'(n_q)) ? (p_q - PW'(n_q)) : p_q);
  end

  // Control FSM with operand latches, accumulator and registered outputs.
  always_ff @(posedge clk or negedge beg) begin
    if (!beg) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            n_q     <= N;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOOP;
          end
        end
        S_LOOP: begin
          p_q   <= p_d;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          out_q       <= res_c;
          out_ready_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_ready = out_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed bench for montgomery_mult: an 8-bit instance driven from a vector
// table plus a 256-bit instance for the wide, abort and restart sequences.
module tb_montgomery_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       beg8, start8, rdy8, busy8;
  logic [7:0] a8, b8, n8, out8;

  logic         beg256, start256, rdy256, busy256;
  logic [255:0] a256, b256, n256, out256;

  montgomery_mult #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .beg(beg8), .start(start8),
    .A(a8), .B(b8), .N(n8),
    .out(out8), .out_ready(rdy8), .busy(busy8)
  );

  montgomery_mult #(.WIDTH(256), .CNT_W(9)) u_dut256 (
    .clk(clk), .beg(beg256), .start(start256),
    .A(a256), .B(b256), .N(n256),
    .out(out256), .out_ready(rdy256), .busy(busy256)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Accept one request on the 8-bit instance and watch 20 cycles after it.
  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                      input bit disturb, output int lat, output int pulses, output int busy_err);
    bit exp_busy;
    a8 = a; b8 = b; n8 = n; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; pulses = 0; busy_err = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      if (rdy8 === 1'b1) begin
        pulses++;
        if (lat == 0) lat = cyc;
      end
      exp_busy = (lat == 0) || (cyc <= lat);
      if (busy8 !== exp_busy) busy_err++;
      if (disturb && cyc == 3) begin
        a8 = 8'd9; b8 = 8'd9; n8 = 8'd251; start8 = 1'b1;
      end
      if (disturb && cyc == 4) start8 = 1'b0;
    end
  endtask

  // Same for the 256-bit instance; abort_at > 0 pulls beg low at that cycle.
  task automatic run256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                        input int abort_at, output int lat, output int pulses,
                        output logic [255:0] out_ab, output logic busy_ab);
    a256 = a; b256 = b; n256 = n; start256 = 1'b1;
    @(posedge clk); #1;
    start256 = 1'b0;
    lat = 0; pulses = 0; out_ab = '1; busy_ab = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        beg256 = 1'b0;
        #1;
        out_ab  = out256;
        busy_ab = busy256;
      end
      if (rdy256 === 1'b1) begin
        pulses++;
        if (lat == 0) lat = cyc;
      end
    end
    beg256 = 1'b1;
    @(posedge clk); #1;
  endtask

  int           lat, pulses, busy_err;
  logic [255:0] out_ab, n_big, two_255, two_254, ones_255;
  logic         busy_ab;

  initial begin
    // Expected values: A*B*R^-1 mod N with R = 256 for the 8-bit instance.
    vecs[0] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  exp: 8'd1};   // 35*3 mod 13
    vecs[1] = '{a: 8'd9,   b: 8'd9,   n: 8'd13,  exp: 8'd9};   // R*R*R^-1 = R
    vecs[2] = '{a: 8'd1,   b: 8'd1,   n: 8'd13,  exp: 8'd3};   // R^-1 mod 13
    vecs[3] = '{a: 8'd0,   b: 8'd12,  n: 8'd13,  exp: 8'd0};
    vecs[4] = '{a: 8'd12,  b: 8'd12,  n: 8'd13,  exp: 8'd3};   // (-1)^2 * 3
    vecs[5] = '{a: 8'd254, b: 8'd254, n: 8'd255, exp: 8'd1};   // carry into top bit of P
    vecs[6] = '{a: 8'd2,   b: 8'd3,   n: 8'd255, exp: 8'd6};   // R == 1 mod 255
    vecs[7] = '{a: 8'd3,   b: 8'd4,   n: 8'd251, exp: 8'd153}; // 12*201 mod 251
    vecs[8] = '{a: 8'd16,  b: 8'd15,  n: 8'd17,  exp: 8'd2};   // R == 1 mod 17

    n_big    = '0; n_big[255] = 1'b1; n_big[0] = 1'b1;   // 2^255 + 1
    two_255  = '0; two_255[255] = 1'b1;
    two_254  = '0; two_254[254] = 1'b1;
    ones_255 = '1; ones_255[255] = 1'b0;                 // 2^255 - 1

    beg8 = 1'b0; start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; n8 = 8'h0F;
    beg256 = 1'b0; start256 = 1'b0; a256 = '1; b256 = '1; n256 = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out8", 256'(out8), 256'd0);
    chk("rst_rdy8", 256'(rdy8), 256'd0);
    chk("rst_busy8", 256'(busy8), 256'd0);
    chk("rst_out256", out256, 256'd0);
    chk("rst_busy256", 256'(busy256), 256'd0);

    // Nothing may start while start stays low.
    beg8 = 1'b1; beg256 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy8", 256'(busy8), 256'd0);

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].n, 1'b0, lat, pulses, busy_err);
      chk($sformatf("v%0d_out", i), 256'(out8), 256'(vecs[i].exp));
      chk($sformatf("v%0d_lat", i), 256'(lat), 256'd10);
      chk($sformatf("v%0d_pulses", i), 256'(pulses), 256'd1);
      chk($sformatf("v%0d_busy", i), 256'(busy_err), 256'd0);
    end

    // Result holds while idle and inputs wander.
    a8 = 8'd1; b8 = 8'd1; n8 = 8'd13;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_out8", 256'(out8), 256'(vecs[8].exp));

    // Second start and changed operands during LOOP are ignored.
    run8(8'd5, 8'd7, 8'd13, 1'b1, lat, pulses, busy_err);
    chk("dist_out", 256'(out8), 256'd1);
    chk("dist_lat", 256'(lat), 256'd10);
    chk("dist_pulses", 256'(pulses), 256'd1);
    chk("dist_busy", 256'(busy_err), 256'd0);

    // Wide run: 2*2*R^-1 mod (2^255+1) = 2^255 - 1 because R == -2.
    run256(256'd2, 256'd2, n_big, 0, lat, pulses, out_ab, busy_ab);
    chk("w_out", out256, ones_255);
    chk("w_lat", 256'(lat), 256'd258);
    chk("w_pulses", 256'(pulses), 256'd1);

    // Abort at cycle 100: outputs clear at once, no out_ready follows.
    run256(two_255, two_255, n_big, 100, lat, pulses, out_ab, busy_ab);
    chk("ab_out", out_ab, 256'd0);
    chk("ab_busy", 256'(busy_ab), 256'd0);
    chk("ab_pulses", 256'(pulses), 256'd0);

    // Restart after release: (-1)*(-1)*(-2)^-1 = 2^254.
    run256(two_255, two_255, n_big, 0, lat, pulses, out_ab, busy_ab);
    chk("rs_out", out256, two_254);
    chk("rs_lat", 256'(lat), 256'd258);
    chk("rs_pulses", 256'(pulses), 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/montgomery_mult.md
Name: montgomery_mult

Overview:
- Bit-serial Montgomery modular multiplier; computes out = A·B·2^(-WIDTH) mod N.
- Sits directly downstream of the pre-processing stage. That stage supplies M·2^WIDTH mod N (Montgomery-domain operand), consumed here as A and/or B.
- The exponentiation controller above this block issues repeated multiply/square requests.
- Radix-2, one operand bit per clock; fixed latency per request.

Parameters:
- WIDTH, 256, operand/modulus width in bits; Montgomery radix R = 2^WIDTH
- CNT_W, 9, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- beg  input  1  asynchronous active-low reset; beg==0 immediately forces reset state
- start  input  1  request strobe; sampled only in IDLE
- A  input  WIDTH  multiplicand; bits scanned LSB first; requires A < N
- B  input  WIDTH  multiplier; requires B < N
- N  input  WIDTH  modulus; requires odd N, N > 1
- out  output  WIDTH  result register; holds last result until the next accepted start
- out_ready  output  1  one-cycle pulse: out is valid
- busy  output  1  high from the cycle after start acceptance through the out_ready cycle

Behaviour:
- Reset (beg==0, async): state=IDLE, counter=0, accumulator=0, out=0, out_ready=0, busy=0. A reset mid-operation aborts; no out_ready is produced for the aborted request.
- States: IDLE, LOOP, FINAL, DONE.
- IDLE:
  - start==1 at a rising edge: latch A, B, N into internal registers; clear accumulator P (WIDTH+2 bits) and counter; go to LOOP.
  - start==0: stay in IDLE.
- LOOP, one iteration per cycle, i = counter:
  - t = P + (Areg[i] ? Breg : 0)
  - if t odd: t = t + Nreg
  - P = t >> 1; counter++
  - After iteration WIDTH-1, go to FINAL. LOOP lasts exactly WIDTH cycles.
- Width rule: P stays < 2N throughout. Intermediate t needs WIDTH+2 bits; no truncation allowed.
- FINAL (1 cycle): out = (P >= Nreg) ? P - Nreg : P, truncated to WIDTH bits. Go to DONE.
- DONE (1 cycle): out_ready=1, busy=1, then go to IDLE.
  - out_ready is registered (asserted in DONE only), never combinational from start.
- Latency: start sampled at edge E0 → out_ready high during the cycle following edge E0+WIDTH+1, i.e. WIDTH+2 cycles after acceptance. Next start is accepted at the first edge in IDLE.
- start while not in IDLE: ignored, not queued.
- A, B, N are sampled only at acceptance. Later changes to the inputs do not affect the running computation.
- Out-of-range inputs (A or B ≥ N, even N): latency unchanged, out unspecified, no lockup.
- out is stable except at the FINAL edge and on reset.

Test Plan:
- WIDTH=8, N=13, A=5, B=7, start pulse → out=1 (35·3 mod 13; R^-1 mod 13 = 3); out_ready exactly 10 cycles after the accepting edge, one cycle wide.
- WIDTH=8, N=13, A=B=9 (R mod N) → out=9; A=1, B=1 → out=3; A=0, B=12 → out=0.
- WIDTH=8, N=255, A=B=254 → out=1 (exercises top carry bit of P); no truncation error.
- WIDTH=256, N=2^255+1, A=B=2 → out = 4·R^-1 mod N. Checked against a reference model; latency 258 cycles.
- Second start pulse mid-LOOP, plus A/B/N changed after acceptance → ignored; result matches the first request; busy continuous; single out_ready.
- beg pulled low at cycle 100 of a 256-bit run → out=0, busy=0 immediately, no out_ready. After release, a new start yields the correct result at normal latency.
